// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard/sequencing bundle between the pipeline datapath and pipe_hazard_ctrl.
// master = the controller, slave = the datapath it steers.
interface pipe_hazard_ctrl_if #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 32
);
  logic [REG_AW-1:0] decRs1Addr;
  logic [REG_AW-1:0] decRs2Addr;
  logic              decRs1Use;
  logic              decRs2Use;
  logic [REG_AW-1:0] aluRdAddr;
  logic              aluWriteEnable;
  logic              aluIsLoad;
  logic              branchTaken;
  logic [REG_AW-1:0] memRdAddr;
  logic              memWriteEnable;
  logic              memReq;
  logic              memReady;
  logic [REG_AW-1:0] wbRdAddr;
  logic              wbWriteEnable;

  logic              pcEnable;
  logic              ifDecEnable;
  logic              decAluEnable;
  logic              aluMemEnable;
  logic              ifDecFlush;
  logic              decAluFlush;
  logic              memWbBubble;
  logic [1:0]        fwdSelA;
  logic [1:0]        fwdSelB;
  logic              memError;
  logic [CNT_W-1:0]  stallCycles;

  modport master (
    input  decRs1Addr, decRs2Addr, decRs1Use, decRs2Use,
    input  aluRdAddr, aluWriteEnable, aluIsLoad, branchTaken,
    input  memRdAddr, memWriteEnable, memReq, memReady,
    input  wbRdAddr, wbWriteEnable,
    output pcEnable, ifDecEnable, decAluEnable, aluMemEnable,
    output ifDecFlush, decAluFlush, memWbBubble,
    output fwdSelA, fwdSelB, memError, stallCycles
  );

  modport slave (
    output decRs1Addr, decRs2Addr, decRs1Use, decRs2Use,
    output aluRdAddr, aluWriteEnable, aluIsLoad, branchTaken,
    output memRdAddr, memWriteEnable, memReq, memReady,
    output wbRdAddr, wbWriteEnable,
    input  pcEnable, ifDecEnable, decAluEnable, aluMemEnable,
    input  ifDecFlush, decAluFlush, memWbBubble,
    input  fwdSelA, fwdSelB, memError, stallCycles
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer for the 5-stage RV32 core: stalls, flushes, forwarding, RAM-wait freeze.
// Define FORWARDING_EN to enable operand forwarding; otherwise every RAW match stalls.
module pipe_hazard_ctrl #(
  parameter int unsigned REG_AW      = 5,
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input logic               clk,
  input logic               reset,
  pipe_hazard_ctrl_if.master bus
);

  localparam int unsigned WCW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WCW-1:0] TimeoutLast = WCW'(MEM_TIMEOUT - 1);

  typedef enum logic [0:0] {StRun, StMemWait} state_e;

  state_e           state_q, state_d;
  logic [WCW-1:0]   wait_q, wait_d;
  logic             mem_err_q, mem_err_d;
  logic [CNT_W-1:0] stall_q;

  logic alu_a, alu_b, mem_a, mem_b, wb_a, wb_b;
  logic hazard, wait_active;
  logic [1:0] fwd_a, fwd_b;
  logic pc_en, ifdec_en, decalu_en, alumem_en, ifdec_fl, decalu_fl, bubble;
  logic [1:0] sel_a, sel_b;

  // x0 is hard-wired zero, so it never counts as a producer.
  function automatic logic reg_match(input logic we, input logic [REG_AW-1:0] rd,
                                     input logic [REG_AW-1:0] rs, input logic rs_used);
    return we && (rd != '0) && (rd == rs) && rs_used;
  endfunction

  always_comb begin
    alu_a = reg_match(bus.aluWriteEnable, bus.aluRdAddr, bus.decRs1Addr, bus.decRs1Use);
    alu_b = reg_match(bus.aluWriteEnable, bus.aluRdAddr, bus.decRs2Addr, bus.decRs2Use);
    mem_a = reg_match(bus.memWriteEnable, bus.memRdAddr, bus.decRs1Addr, bus.decRs1Use);
    mem_b = reg_match(bus.memWriteEnable, bus.memRdAddr, bus.decRs2Addr, bus.decRs2Use);
    wb_a  = reg_match(bus.wbWriteEnable, bus.wbRdAddr, bus.decRs1Addr, bus.decRs1Use);
    wb_b  = reg_match(bus.wbWriteEnable, bus.wbRdAddr, bus.decRs2Addr, bus.decRs2Use);
`ifdef FORWARDING_EN
    hazard = bus.aluIsLoad && (alu_a || alu_b);
    fwd_a  = mem_a ? 2'b01 : (wb_a ? 2'b10 : 2'b00);
    fwd_b  = mem_b ? 2'b01 : (wb_b ? 2'b10 : 2'b00);
`else
    hazard = alu_a || alu_b || mem_a || mem_b || wb_a || wb_b;
    fwd_a  = 2'b00;
    fwd_b  = 2'b00;
`endif
  end

  // In MEM_WAIT the outstanding access keeps the pipe frozen until memReady.
  assign wait_active = (state_q == StMemWait) ? !bus.memReady
                                              : (bus.memReq && !bus.memReady);

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    mem_err_d = mem_err_q;
    pc_en     = 1'b1;
    ifdec_en  = 1'b1;
    decalu_en = 1'b1;
    alumem_en = 1'b1;
    ifdec_fl  = 1'b0;
    decalu_fl = 1'b0;
    bubble    = 1'b0;
    sel_a     = fwd_a;
    sel_b     = fwd_b;

    if (reset) begin
      pc_en     = 1'b0;
      ifdec_en  = 1'b0;
      decalu_en = 1'b0;
      alumem_en = 1'b0;
      ifdec_fl  = 1'b1;
      decalu_fl = 1'b1;
      bubble    = 1'b1;
      sel_a     = 2'b00;
      sel_b     = 2'b00;
    end else if (wait_active) begin
      pc_en     = 1'b0;
      ifdec_en  = 1'b0;
      decalu_en = 1'b0;
      alumem_en = 1'b0;
      bubble    = 1'b1;
      if (wait_q == TimeoutLast) begin
        // Give up on the access and resume; the error stays latched.
        mem_err_d = 1'b1;
        state_d   = StRun;
        wait_d    = '0;
      end else begin
        state_d = StMemWait;
        wait_d  = wait_q + WCW'(1);
      end
    end else begin
      state_d = StRun;
      wait_d  = '0;
      if (bus.branchTaken) begin
        ifdec_fl  = 1'b1;
        decalu_fl = 1'b1;
      end else if (hazard) begin
        pc_en     = 1'b0;
        ifdec_en  = 1'b0;
        decalu_fl = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StRun;
      wait_q    <= '0;
      mem_err_q <= 1'b0;
      stall_q   <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      mem_err_q <= mem_err_d;
      if (!pc_en && (stall_q != '1)) begin
        stall_q <= stall_q + CNT_W'(1);
      end
    end
  end

  assign bus.pcEnable     = pc_en;
  assign bus.ifDecEnable  = ifdec_en;
  assign bus.decAluEnable = decalu_en;
  assign bus.aluMemEnable = alumem_en;
  assign bus.ifDecFlush   = ifdec_fl;
  assign bus.decAluFlush  = decalu_fl;
  assign bus.memWbBubble  = bubble;
  assign bus.fwdSelA      = sel_a;
  assign bus.fwdSelB      = sel_b;
  assign bus.memError     = mem_err_q;
  assign bus.stallCycles  = stall_q;

endmodule
